jtdsp16_sio_tx: RTL and testbench

Serial output transmitter for the jtdsp16 core. It takes 16-bit words written by the DSP program to the serial output buffer and shifts them out on `sdo`, with `ock`, `psel`, `sadd` and `doen` framing. The QSound glue deserialises this stream into left/right samples: bits are sampled on the falling edge of `ock`, and a rising edge of `psel` marks a sample pair. The block sits inside jtdsp16, between the register-file write path and the serial pins.

---
 rtl/jtdsp16_sio_pkg.sv | 10 +
 rtl/jtdsp16_sio_ckgen.sv | 33 +++
 rtl/jtdsp16_sio_tx.sv | 115 +++++++++++
 tb/tb_jtdsp16_sio_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_sio_pkg.sv
// Shared types and widths for the jtdsp16 serial output transmitter.
package jtdsp16_sio_pkg;
    localparam int SIO_WORD_W = 16;
    localparam int SIO_CNT_W  = $clog2(SIO_WORD_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sio_state_t;
endpackage

// File: rtl/jtdsp16_sio_ckgen.sv
// Free-running ock divider: toggles every CKDIV clk_en ticks, with rise/fall
// strobes that are high on the tick where ock changes.
module jtdsp16_sio_ckgen #(
    parameter int CKDIV = 4
) (
    input  logic rst,
    input  logic clk,
    input  logic clk_en,
    output logic ock,
    output logic rise,
    output logic fall
);
    logic [7:0] cnt;
    logic       wrap;

    assign wrap = clk_en && (cnt == 8'(CKDIV - 1));
    assign rise = wrap && !ock;
    assign fall = wrap && ock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
            ock <= 1'b0;
        end else if (clk_en) begin
            if (wrap) begin
                cnt <= 8'd0;
                ock <= ~ock;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/jtdsp16_sio_tx.sv
// jtdsp16 serial output transmitter: obuf + shifter + framing on sdo/psel/sadd/doen.
// Define JTDSP16_SIO_LSBFIRST_EN to send words LSB first (default MSB first).
module jtdsp16_sio_tx
    import jtdsp16_sio_pkg::*;
#(
    parameter int CKDIV = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        clk_en,
    input  logic        tx_we,
    input  logic [15:0] tx_data,
    input  logic        tx_chan,
    output logic        ock,
    output logic        sdo,
    output logic        doen,
    output logic        sadd,
    output logic        psel,
    output logic        old,
    output logic        ose,
    output logic        ovf
);
`ifdef JTDSP16_SIO_LSBFIRST_EN
    localparam int FIRST = 0;
`else
    localparam int FIRST = SIO_WORD_W - 1;
`endif

    sio_state_t                state, state_nx;
    logic                      rise, fall;
    logic                      obuf_full, obuf_chan;
    logic [SIO_WORD_W-1:0]     obuf_data, shreg;
    logic [SIO_CNT_W-1:0]      bcnt;
    logic                      last_bit, load;

    jtdsp16_sio_ckgen #(.CKDIV(CKDIV)) u_ckgen (
        .rst    (rst),
        .clk    (clk),
        .clk_en (clk_en),
        .ock    (ock),
        .rise   (rise),
        .fall   (fall)
    );

    assign last_bit = (bcnt == SIO_CNT_W'(SIO_WORD_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rise && obuf_full) state_nx = SHIFT;
            SHIFT:   if (rise && last_bit && !obuf_full) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load = rise && obuf_full && (state == IDLE || last_bit);
        doen = (state == SHIFT);
        ose  = (state == IDLE) && !obuf_full;
    end

    // sdo is refreshed on rises from the shifter head; the shifter advances
    // on falls so the next bit is already waiting at the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obuf_full <= 1'b0;
            obuf_chan <= 1'b0;
            obuf_data <= '0;
            shreg     <= '0;
            bcnt      <= '0;
            sdo       <= 1'b0;
            sadd      <= 1'b0;
            psel      <= 1'b0;
            old       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            old <= load;
            ovf <= tx_we && obuf_full && !load;
            if (tx_we) begin
                obuf_data <= tx_data;
                obuf_chan <= tx_chan;
                obuf_full <= 1'b1;
            end else if (load) begin
                obuf_full <= 1'b0;
            end
            if (load) begin
                shreg <= obuf_data;
                sdo   <= obuf_data[FIRST];
                psel  <= obuf_chan;
                sadd  <= 1'b1;
                bcnt  <= '0;
            end else if (state == SHIFT && rise) begin
                sadd <= 1'b0;
                if (last_bit) begin
                    sdo  <= 1'b0;
                    bcnt <= '0;
                end else begin
                    sdo  <= shreg[FIRST];
                    bcnt <= bcnt + 1'b1;
                end
            end else if (state == SHIFT && fall) begin
`ifdef JTDSP16_SIO_LSBFIRST_EN
                shreg <= {1'b0, shreg[SIO_WORD_W-1:1]};
`else
                shreg <= {shreg[SIO_WORD_W-2:0], 1'b0};
`endif
            end
        end
    end
endmodule

// File: tb/tb_jtdsp16_sio_tx.sv
// Bench for jtdsp16_sio_tx: two instances (CKDIV=4 and CKDIV=1) against a
// tick/period-count reference model, plus a receiver sampling sdo on ock falls.
module tb_jtdsp16_sio_tx;
`ifdef JTDSP16_SIO_LSBFIRST_EN
    localparam bit LSBF = 1'b1;
`else
    localparam bit LSBF = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, clk_en = 1'b0, tx_we = 1'b0, tx_chan = 1'b0;
    logic [15:0] tx_data = '0;
    logic [1:0]  ock_w, sdo_w, doen_w, sadd_w, psel_w, old_w, ose_w, ovf_w;

    always #5 clk = ~clk;

    jtdsp16_sio_tx #(.CKDIV(4)) dut4 (
        .rst(rst), .clk(clk), .clk_en(clk_en), .tx_we(tx_we), .tx_data(tx_data),
        .tx_chan(tx_chan), .ock(ock_w[0]), .sdo(sdo_w[0]), .doen(doen_w[0]),
        .sadd(sadd_w[0]), .psel(psel_w[0]), .old(old_w[0]), .ose(ose_w[0]), .ovf(ovf_w[0])
    );
    jtdsp16_sio_tx #(.CKDIV(1)) dut1 (
        .rst(rst), .clk(clk), .clk_en(clk_en), .tx_we(tx_we), .tx_data(tx_data),
        .tx_chan(tx_chan), .ock(ock_w[1]), .sdo(sdo_w[1]), .doen(doen_w[1]),
        .sadd(sadd_w[1]), .psel(psel_w[1]), .old(old_w[1]), .ose(ose_w[1]), .ovf(ovf_w[1])
    );

    int checks = 0, failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each word occupies 16 ock periods starting on a rise;
    // rises fall on tick indices t where t mod 2C == C-1.
    int          C[2] = '{4, 1};
    int          tk[2], rem[2];
    bit          pend[2], pc[2], ps[2], old_e[2], ovf_e[2];
    logic [15:0] pw[2], cw[2];

    function automatic void mdl_reset();
        for (int i = 0; i < 2; i++) begin
            tk[i] = 0; rem[i] = 0; pend[i] = 0; pc[i] = 0; ps[i] = 0;
            old_e[i] = 0; ovf_e[i] = 0; pw[i] = '0; cw[i] = '0;
        end
    endfunction

    function automatic void mdl_step(bit en, bit we, logic [15:0] d, bit ch);
        for (int i = 0; i < 2; i++) begin
            old_e[i] = 0; ovf_e[i] = 0;
            if (en) begin
                if (tk[i] % (2 * C[i]) == C[i] - 1) begin
                    if (rem[i] > 0) rem[i]--;
                    if (rem[i] == 0 && pend[i]) begin
                        cw[i] = pw[i]; ps[i] = pc[i]; rem[i] = 16; pend[i] = 0; old_e[i] = 1;
                    end
                end
                tk[i]++;
            end
            if (we) begin
                ovf_e[i] = pend[i]; pend[i] = 1; pw[i] = d; pc[i] = ch;
            end
        end
    endfunction

    function automatic bit sdo_x(int i);
        logic [15:0] w;
        if (rem[i] == 0) return 1'b0;
        w = cw[i];
        return LSBF ? w[16 - rem[i]] : w[rem[i] - 1];
    endfunction

    // Receiver on the CKDIV=4 instance plus event counters
    logic [15:0] rx, left;
    logic [15:0] rxq[$];
    int          rxn, old_cnt, ovf_cnt, doen_cnt;
    bit          rx_first, prev_ock, prev_psel;

    function automatic void rx_reset();
        rx = '0; rxn = 0; prev_ock = 0; prev_psel = 0;
    endfunction

    task automatic cyc(bit en, bit we, logic [15:0] d, bit ch);
        clk_en = en; tx_we = we; tx_data = d; tx_chan = ch;
        @(posedge clk);
        mdl_step(en, we, d, ch);
        #1;
        tx_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ock%0d", i),  ock_w[i],  (tk[i] / C[i]) % 2);
            chk($sformatf("sdo%0d", i),  sdo_w[i],  sdo_x(i));
            chk($sformatf("doen%0d", i), doen_w[i], rem[i] > 0);
            chk($sformatf("sadd%0d", i), sadd_w[i], rem[i] == 16);
            chk($sformatf("psel%0d", i), psel_w[i], ps[i]);
            chk($sformatf("old%0d", i),  old_w[i],  old_e[i]);
            chk($sformatf("ose%0d", i),  ose_w[i],  rem[i] == 0 && !pend[i]);
            chk($sformatf("ovf%0d", i),  ovf_w[i],  ovf_e[i]);
        end
        if (old_w[0])  old_cnt++;
        if (ovf_w[0])  ovf_cnt++;
        if (doen_w[0]) doen_cnt++;
        if (prev_ock && !ock_w[0] && doen_w[0]) begin
            if (rxn == 0) rx_first = sdo_w[0];
            rx = LSBF ? {sdo_w[0], rx[15:1]} : {rx[14:0], sdo_w[0]};
            rxn++;
            if (rxn == 16) begin rxq.push_back(rx); rxn = 0; end
        end
        if (!prev_psel && psel_w[0]) left = (rxq.size() > 0) ? rxq[$] : 16'h0;
        prev_ock  = ock_w[0];
        prev_psel = psel_w[0];
    endtask

    task automatic chk_rst(string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ock"}, ock_w[i], 0);   chk({tag, "_sdo"}, sdo_w[i], 0);
            chk({tag, "_doen"}, doen_w[i], 0); chk({tag, "_sadd"}, sadd_w[i], 0);
            chk({tag, "_psel"}, psel_w[i], 0); chk({tag, "_old"}, old_w[i], 0);
            chk({tag, "_ose"}, ose_w[i], 1);   chk({tag, "_ovf"}, ovf_w[i], 0);
        end
    endtask

    task automatic run_until_ose(int max, string nm);
        int n = 0;
        while (!ose_w[0] && n < max) begin
            cyc(1, 0, 16'h0, 0);
            n++;
        end
        chk(nm, ose_w[0], 1);
    endtask

    task automatic wait_doen(int max, string nm);
        int n = 0;
        while (!doen_w[0] && n < max) begin
            cyc(1, 0, 16'h0, 0);
            n++;
        end
        chk(nm, doen_w[0], 1);
    endtask

    typedef struct {
        logic [15:0] data;
        bit          chan;
        logic [15:0] exp_word;
        bit          exp_psel;
        bit          exp_first;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{16'hA5F0, 1'b0, 16'hA5F0, 1'b0, LSBF ? 1'b0 : 1'b1};
        tbl[1] = '{16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0};
        tbl[2] = '{16'h0001, 1'b0, 16'h0001, 1'b0, LSBF ? 1'b1 : 1'b0};
        tbl[3] = '{16'h8000, 1'b1, 16'h8000, 1'b1, LSBF ? 1'b0 : 1'b1};

        mdl_reset(); rx_reset(); left = '0; rx_first = 0;
        #1 rst = 1'b1;
        #2 chk_rst("rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) cyc(1, 0, 16'h0, 0);

        // single words, one at a time
        foreach (tbl[v]) begin
            old_cnt = 0; doen_cnt = 0;
            cyc(1, 1, tbl[v].data, tbl[v].chan);
            run_until_ose(400, "single_done");
            chk($sformatf("word%0d", v), (rxq.size() > 0) ? rxq[$] : 16'hxxxx, tbl[v].exp_word);
            chk($sformatf("first%0d", v), rx_first, tbl[v].exp_first);
            chk($sformatf("psel_hold%0d", v), psel_w[0], tbl[v].exp_psel);
            chk($sformatf("old_cnt%0d", v), old_cnt, 1);
            chk($sformatf("doen_len%0d", v), doen_cnt, 16 * 2 * 4);
            for (int k = 0; k < 6; k++) cyc(1, 0, 16'h0, 0);
        end

        // stereo pair, gapless
        doen_cnt = 0; old_cnt = 0;
        cyc(1, 1, 16'h1234, 0);
        wait_doen(20, "stereo_start");
        for (int k = 0; k < 20; k++) cyc(1, 0, 16'h0, 0);
        cyc(1, 1, 16'hFEDC, 1);
        run_until_ose(600, "stereo_done");
        chk("stereo_w0", (rxq.size() > 1) ? rxq[$-1] : 16'hxxxx, 16'h1234);
        chk("stereo_w1", (rxq.size() > 0) ? rxq[$] : 16'hxxxx, 16'hFEDC);
        chk("stereo_left", left, 16'h1234);
        chk("stereo_gapless", doen_cnt, 2 * 16 * 2 * 4);
        chk("stereo_old", old_cnt, 2);

        // overwrite while shifting
        ovf_cnt = 0;
        cyc(1, 1, 16'hAAAA, 0);
        wait_doen(20, "ovw_start");
        for (int k = 0; k < 10; k++) cyc(1, 0, 16'h0, 0);
        cyc(1, 1, 16'h1111, 0);
        for (int k = 0; k < 10; k++) cyc(1, 0, 16'h0, 0);
        cyc(1, 1, 16'h2222, 1);
        run_until_ose(600, "ovw_done");
        chk("ovw_ovf_cnt", ovf_cnt, 1);
        chk("ovw_w0", (rxq.size() > 1) ? rxq[$-1] : 16'hxxxx, 16'hAAAA);
        chk("ovw_w1", (rxq.size() > 0) ? rxq[$] : 16'hxxxx, 16'h2222);

        // clk_en toggling 1/0
        for (int k = 0; k < 300; k++) begin
            bit we = (k == 3) || (k == 40) || (k == 150);
            cyc(k % 2 == 0, we, 16'hC3A5 ^ 16'(k), k[0]);
        end

        // reset mid-word with a pending obuf write
        cyc(1, 1, 16'h8001, 0);
        begin
            int n = 0;
            while (rem[0] != 8 && n < 200) begin
                cyc(1, n == 30, 16'h5555, 1);
                n++;
            end
            chk("rst_reach_bit7", rem[0], 8);
        end
        #2 rst = 1'b1;
        #1 chk_rst("midrst");
        mdl_reset(); rx_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        doen_cnt = 0; old_cnt = 0;
        for (int k = 0; k < 300; k++) cyc(1, 0, 16'h0, 0);
        chk("midrst_no_resume", doen_cnt, 0);
        chk("midrst_no_old", old_cnt, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                16'($urandom), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
